// File: rtl/sync_fifo_buffer.sv
// Single-clock valid/ready FIFO with DEPTH = 2^M entries and an occupancy count.
// No fall-through: a written word shows up at the output on the cycle after its write edge.
module sync_fifo_buffer #(
  parameter int Nb = 48,
  parameter int M  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Nb-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Nb-1:0] out_data,
  output logic [M:0]    count
);

  localparam int DEPTH = 2 ** M;
  localparam logic [M:0] FULL_COUNT = {1'b1, {M{1'b0}}};

  logic [Nb-1:0] mem [DEPTH];
  logic [M-1:0]  wr_ptr_reg;
  logic [M-1:0]  rd_ptr_reg;
  logic [M:0]    count_reg;
  logic [M:0]    count_next;
  logic          wr_fire;
  logic          rd_fire;

  // Handshake flags depend only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign out_data  = mem[rd_ptr_reg];
  assign count     = count_reg;

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    case ({wr_fire, rd_fire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_reg] <= in_data;
  end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Bench for sync_fifo_buffer: queue-based reference model checked every cycle,
// plus directed phases with literal expectations.
module tb_sync_fifo_buffer;

  localparam int NB = 48;
  localparam int MW = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
  logic [MW:0]   count;

  int total = 0;
  int bad = 0;

  logic [NB-1:0] model_q [$];
  logic [NB-1:0] rx_q [$];

  sync_fifo_buffer #(.Nb(NB), .M(MW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of accepted words.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else begin
      automatic bit rd = out_ready && (model_q.size() > 0);
      automatic bit wr = in_valid && (model_q.size() < DEPTH);
      if (rd) void'(model_q.pop_front());
      if (wr) model_q.push_back(in_data);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_count", 64'(count), 64'(model_q.size()));
    check("model_in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
    check("model_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) check("model_out_data", 64'(out_data), 64'(model_q[0]));
  end

  // Apply inputs just after a rising edge; they are sampled at the next one.
  task automatic drive(input logic v, input logic [NB-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Fill phase: five writes with no reads, only four fit.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, NB'(i), 1'b0);
      tick();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_model_size", 64'(model_q.size()), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, 1'b1);
      check($sformatf("drain_data_%0d", i), 64'(out_data), 64'(i));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    $display("phase fill/drain: total=%0d bad=%0d", total, bad);

    // Latency: one write into an empty FIFO.
    drive(1'b1, 48'hABCDEF, 1'b0);
    check("lat_valid_before", 64'(out_valid), 64'd0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("lat_valid_after", 64'(out_valid), 64'd1);
    check("lat_data_after", 64'(out_data), 64'hABCDEF);
    drive(1'b0, '0, 1'b1);
    tick();
    check("lat_empty", 64'(count), 64'd0);
    $display("phase latency: total=%0d bad=%0d", total, bad);

    // Streaming: continuous write and read of 0..99.
    rx_q.delete();
    for (int i = 0; i <= 100; i++) begin
      drive(i < 100, NB'(i), 1'b1);
      if (out_valid) rx_q.push_back(out_data);
      tick();
      if (i == 50) check("stream_count", 64'(count), 64'd1);
    end
    check("stream_rx_size", 64'(rx_q.size()), 64'd100);
    begin
      automatic int order_err = 0;
      foreach (rx_q[k]) if (rx_q[k] !== NB'(k)) order_err++;
      check("stream_order_errors", 64'(order_err), 64'd0);
    end
    check("stream_end_count", 64'(count), 64'd0);
    $display("phase streaming: total=%0d bad=%0d", total, bad);

    // Boundary: full with simultaneous read and write.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, NB'(10 + i), 1'b0);
      tick();
    end
    drive(1'b1, NB'(14), 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("full_rw_count", 64'(count), 64'd3);
    check("full_rw_head", 64'(out_data), 64'd11);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("full_rw_drained", 64'(count), 64'd0);

    // Boundary: empty with simultaneous read and write.
    drive(1'b1, NB'(20), 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("empty_rw_count", 64'(count), 64'd1);
    check("empty_rw_data", 64'(out_data), 64'd20);
    drive(1'b0, '0, 1'b1);
    tick();
    $display("phase boundaries: total=%0d bad=%0d", total, bad);

    // Mid-operation asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, NB'(30 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("pre_reset_count", 64'(count), 64'd3);
    reset = 1'b1;
    #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    #1;
    reset = 1'b0;
    tick();
    drive(1'b1, 48'h77, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data", 64'(out_data), 64'h77);
    check("post_rst_count", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b1);
    tick();
    tick();
    $display("phase reset: total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_buffer.md
Name: sync_fifo_buffer

Overview:
Single-clock, first-in first-out buffer with valid/ready handshakes on both sides and an occupancy count output. It decouples a sample producer from a sample consumer in the same clock domain, e.g. looping 48-bit sample words from a DAC slot model to an ADC slot model on the master clock. Both sides follow the codebase's FIFOInterface convention, flattened to the in_* and out_* signals listed under Ports.

Parameters:
- Nb, 48, data word width in bits.
- M, 2, log2 of depth; DEPTH = 2^M entries (default 4).

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data (FIFOInterface in.valid).
- in_ready  output  1  FIFO can accept a word this cycle (in.ready).
- in_data  input  Nb  write data (in.data).
- out_valid  output  1  out_data holds the oldest stored word (out.valid).
- out_ready  input  1  consumer takes the word this cycle (out.ready).
- out_data  output  Nb  read data (out.data).
- count  output  M+1  number of stored words, 0..DEPTH.

Behaviour:
- Storage: DEPTH x Nb register array, write pointer wr_ptr[M-1:0], read pointer rd_ptr[M-1:0], occupancy register count[M:0].
- Pointers wrap modulo DEPTH.
- Write fires when in_valid && in_ready:
  - mem[wr_ptr] <= in_data;
  - wr_ptr increments.
- Read fires when out_valid && out_ready: rd_ptr increments.
- Count update:
  - write only: +1;
  - read only: -1;
  - both, or neither: unchanged.
- in_ready = (count != DEPTH). It is combinational from registered count only and has no path from out_ready.
- When full, a write is refused even if a read fires in the same cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr], combinational from registered state.
- No fall-through: a word written into an empty FIFO becomes visible (out_valid=1) on the cycle after the write edge. Write-to-read latency is 1 clock.
- Simultaneous read and write with 0 < count < DEPTH: both fire, count is unchanged, and data order is preserved.
- Read while empty is ignored (out_valid=0). Write while full is ignored (in_ready=0). No overflow or underflow.
- out_data while out_valid=0 is don't-care. The memory array is not reset.
- Reset (asserted asynchronously):
  - wr_ptr, rd_ptr and count go to 0 immediately;
  - so out_valid=0, in_ready=1, count=0.
- Reset mid-operation discards all stored words.
- Operation resumes on the first rising clk edge after reset deasserts.
- Strict FIFO ordering: words leave in exactly the order accepted, with no duplication or loss.

Test Plan:
- Reset: assert reset with no clock -> in_ready=1, out_valid=0, count=0 immediately.
- Fill: with out_ready=0, write 48'h1, 48'h2, 48'h3, 48'h4, 48'h5 on consecutive cycles -> first four accepted, count=4, in_ready=0, fifth refused. Then drain with out_ready=1 -> out_data 1,2,3,4 in order, count returns to 0.
- Latency: write 48'hABCDEF into an empty FIFO -> out_valid=0 in the write cycle, out_valid=1 with out_data=48'hABCDEF one cycle later.
- Streaming: in_valid=1 and out_ready=1 continuously with incrementing data 0..99 -> count steady at 1, and all 100 words are received in order across multiple pointer wraps.
- Boundaries:
  - full (count=4), in_valid=1, out_ready=1 -> read fires, write refused, count=3;
  - empty, in_valid=1, out_ready=1 -> write fires, read does not, count=1.
- Mid-operation reset: load 3 words, pulse reset between clock edges -> count=0 and out_valid=0 at once. Then writing 48'h77 -> 48'h77 is the next word out.
